// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and types for the RV32I register bank
package regfile_pkg;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_addr_decoder.sv
// rtl/wb_addr_decoder.sv - write-back index to one-hot register select
module wb_addr_decoder
    import regfile_pkg::*;
(
    input  logic            en,
    input  reg_idx_t        idx,
    output logic [NREG-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_write_bank.sv
// rtl/regfile_write_bank.sv - RV32I register bank, one write port, two read ports
// REGFILE_BYPASS_EN: forward same-cycle write data onto the rs1/rs2 read ports.
module regfile_write_bank
    import regfile_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rd_wren,
    input  reg_idx_t             i_rd_addr,
    input  word_t                i_rd_data,
    input  reg_idx_t             i_rs1_addr,
    input  reg_idx_t             i_rs2_addr,
    output word_t                o_rs1_data,
    output word_t                o_rs2_data,
    output logic [NREG*XLEN-1:0] o_regs,
    output logic [CNT_W-1:0]     o_wr_count
);
    // x0 has no storage; only x1..x31 are real flops.
    word_t           regs [1:NREG-1];
    logic [NREG-1:0] wr_sel;
    logic            commit;
    logic            x0_sel_unused;
    word_t           rs1_stored;
    word_t           rs2_stored;

    wb_addr_decoder u_dec (
        .en     (i_rd_wren),
        .idx    (i_rd_addr),
        .onehot (wr_sel)
    );

    assign x0_sel_unused = wr_sel[0];
    assign commit        = |wr_sel[NREG-1:1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 1; k < NREG; k++) begin
                regs[k] <= '0;
            end
            o_wr_count <= '0;
        end else begin
            for (int k = 1; k < NREG; k++) begin
                if (wr_sel[k]) begin
                    regs[k] <= i_rd_data;
                end
            end
            if (commit) begin
                o_wr_count <= o_wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        o_regs     = '0;
        for (int k = 1; k < NREG; k++) begin
            rs1_stored = rs1_stored | (regs[k] & {XLEN{i_rs1_addr == reg_idx_t'(k)}});
            rs2_stored = rs2_stored | (regs[k] & {XLEN{i_rs2_addr == reg_idx_t'(k)}});
            o_regs[k*XLEN +: XLEN] = regs[k];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward only when the write would commit, so x0 still reads zero.
    always_comb begin
        o_rs1_data = rs1_stored;
        o_rs2_data = rs2_stored;
        if (commit && (i_rs1_addr == i_rd_addr)) begin
            o_rs1_data = i_rd_data;
        end
        if (commit && (i_rs2_addr == i_rd_addr)) begin
            o_rs2_data = i_rd_data;
        end
    end
`else
    assign o_rs1_data = rs1_stored;
    assign o_rs2_data = rs2_stored;
`endif
endmodule

// File: tb/tb_regfile_write_bank.sv
// tb/tb_regfile_write_bank.sv - directed and random checks against a reference model
module tb_regfile_write_bank;
    logic          clk = 1'b0;
    logic          reset;
    logic          wren;
    logic [4:0]    rd_addr;
    logic [31:0]   rd_data;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [31:0]   rs1_a, rs2_a, rs1_b, rs2_b;
    logic [1023:0] regs_a, regs_b;
    logic [31:0]   cnt_a;
    logic [3:0]    cnt_b;

    logic [31:0]   m_regs [32];
    int unsigned   m_count;
    int            checks = 0;
    int            fails  = 0;

    always #5 clk = ~clk;

    regfile_write_bank #(.CNT_W(32)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_rd_wren(wren), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(rs1_a), .o_rs2_data(rs2_a), .o_regs(regs_a), .o_wr_count(cnt_a)
    );

    regfile_write_bank #(.CNT_W(4)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_rd_wren(wren), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(rs1_b), .o_rs2_data(rs2_b), .o_regs(regs_b), .o_wr_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: architectural register state, read value and commit rule.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (wren && rd_addr != 5'd0 && a == rd_addr) v = rd_data;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            foreach (m_regs[k]) m_regs[k] = 32'd0;
            m_count = 0;
        end else if (wren && rd_addr != 5'd0) begin
            m_regs[rd_addr] = rd_data;
            m_count++;
        end
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; wren = we; rd_addr = rd; rd_data = d; rs1_addr = r1; rs2_addr = r2;
        #1;
    endtask

    task automatic chk_reads(input string tag);
        chk({tag, "_rs1"},   rs1_a, exp_read(rs1_addr));
        chk({tag, "_rs2"},   rs2_a, exp_read(rs2_addr));
        chk({tag, "_rs1_b"}, rs1_b, exp_read(rs1_addr));
        chk({tag, "_rs2_b"}, rs2_b, exp_read(rs2_addr));
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_cnt"},   cnt_a, m_count);
        chk({tag, "_cnt4"},  {28'd0, cnt_b}, m_count % 16);
    endtask

    task automatic chk_image(input string tag);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("%s_regs%0d", tag, k),   regs_a[k*32 +: 32], m_regs[k]);
            chk($sformatf("%s_regs_b%0d", tag, k), regs_b[k*32 +: 32], m_regs[k]);
        end
    endtask

    initial begin
        foreach (m_regs[k]) m_regs[k] = 32'd0;
        m_count = 0;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clk); #1;

        // 1: reset held two cycles with random writes
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk_image("reset");
        chk_counts("reset");

        // 2: write x5, read back next cycle
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        chk_reads("x5_same");
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        chk("x5_rs1", rs1_a, 32'hDEADBEEF);
        chk_counts("x5");

        // 3: writes to x0 are dropped
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk_reads("x0_same");
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("x0_rs1", rs1_a, 32'd0);
        chk("x0_regs", regs_a[31:0], 32'd0);
        chk("x0_cnt", cnt_a, 32'd1);

        // 4: same-cycle read of x7 (bypass-dependent), then registered read
        drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd7);
`ifdef REGFILE_BYPASS_EN
        chk("x7_same", rs2_a, 32'h12345678);
`else
        chk("x7_same", rs2_a, 32'd0);
`endif
        chk_reads("x7_same");
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7);
        chk("x7_next", rs2_a, 32'h12345678);

        // 5: reset beats a same-cycle write; next write commits
        drive(1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0);
        chk("x31_reset", rs1_a, 32'd0);
        chk_counts("x31_reset");
        drive(1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0);
        chk("x31_after", rs1_a, 32'hA5A5A5A5);
        chk("x31_cnt", cnt_a, 32'd1);

        // 6: fill x1..x31 from reset; CNT_W=4 instance wraps after 16
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 1'b1, 5'(k), 32'(k) * 32'h01010101, 5'($urandom), 5'($urandom));
            tick();
            if (k == 17) chk("wrap17", {28'd0, cnt_b}, 32'd1);
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk_image("fill");
        chk("fill_cnt", cnt_a, 32'd31);

        // Random traffic, including idle cycles with garbage address/data
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom), $urandom, 5'($urandom), 5'($urandom));
            chk_reads($sformatf("rnd%0d", i));
            tick();
            chk_counts($sformatf("rnd%0d", i));
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk_image("final");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
